// File: rtl/rf_debug_dumper_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_debug_dumper_if
// Brief    : Register-file A read port plus valid/ready debug stream, bundled
//            for the register-file debug dumper.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_debug_dumper_if #(
    parameter int AW = 3,
    parameter int DW = 16
);
    logic          rf_own;
    logic [AW-1:0] rf_regA;
    logic [DW-1:0] rf_dataA;
    logic          dbg_valid;
    logic          dbg_ready;
    logic [AW-1:0] dbg_idx;
    logic [DW-1:0] dbg_data;

    // Dumper side: drives the RF address and the debug stream
    modport master (
        output rf_own,
        output rf_regA,
        input  rf_dataA,
        output dbg_valid,
        input  dbg_ready,
        output dbg_idx,
        output dbg_data
    );

    // Register file / debug consumer side
    modport slave (
        input  rf_own,
        input  rf_regA,
        output rf_dataA,
        input  dbg_valid,
        output dbg_ready,
        input  dbg_idx,
        input  dbg_data
    );
endinterface
`default_nettype wire

// File: rtl/rf_debug_dumper.sv
`default_nettype none
// ============================================================================
// Module   : rf_debug_dumper
// Brief    : Walks the register file through its A read port while the core
//            is halted and streams {index, value} pairs over a valid/ready
//            debug channel. Accounts for the one-cycle registered RF read.
// Revision : 1.0 - initial release
// ============================================================================
module rf_debug_dumper #(
    parameter int NREGS = 8,
    parameter int AW    = 3,
    parameter int DW    = 16
) (
    input  wire logic           CLK,
    input  wire logic           reset,
    input  wire logic           start,
    input  wire logic           halt_ack,
    output logic                busy,
    output logic                done,
    rf_debug_dumper_if.master   bus
);

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_HALT = 3'd1,
        S_ADDR      = 3'd2,
        S_CAPTURE   = 3'd3,
        S_SEND      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx_nxt;
    logic [AW-1:0] r_dbg_idx;
    logic [DW-1:0] r_dbg_data;
    logic          w_capture;
    logic          w_rf_own;
    logic [AW-1:0] w_rf_regA;
    logic          w_dbg_valid;
    logic          w_busy;
    logic          w_done;

    // Next-state, index update and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_rf_own    = 1'b0;
        w_rf_regA   = '0;
        w_dbg_valid = 1'b0;
        w_busy      = (r_state != S_IDLE);
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_WAIT_HALT;
                    w_idx_nxt   = '0;
                end
            end
            S_WAIT_HALT: begin
                if (halt_ack) begin
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                // RF registers the address at the end of this cycle
                w_rf_own    = 1'b1;
                w_rf_regA   = r_idx;
                w_state_nxt = halt_ack ? S_CAPTURE : S_WAIT_HALT;
            end
            S_CAPTURE: begin
                // Data for r_idx is on rf_dataA now; only trust it if still halted
                w_rf_own  = 1'b1;
                w_rf_regA = r_idx;
                if (halt_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_WAIT_HALT;
                end
            end
            S_SEND: begin
                // Word already captured, so halt_ack no longer matters here
                w_dbg_valid = 1'b1;
                if (bus.dbg_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = halt_ack ? S_ADDR : S_WAIT_HALT;
                    end
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // State, index and captured-word registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_dbg_idx  <= '0;
            r_dbg_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_capture) begin
                r_dbg_idx  <= r_idx;
                r_dbg_data <= bus.rf_dataA;
            end
        end
    end

    assign bus.rf_own    = w_rf_own;
    assign bus.rf_regA   = w_rf_regA;
    assign bus.dbg_valid = w_dbg_valid;
    assign bus.dbg_idx   = r_dbg_idx;
    assign bus.dbg_data  = r_dbg_data;
    assign busy          = w_busy;
    assign done          = w_done;

endmodule
`default_nettype wire

// File: tb/tb_rf_debug_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_debug_dumper
// Brief    : Self-checking bench for rf_debug_dumper: RF model, randomized
//            backpressure/halt stimulus and an in-order word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_debug_dumper;

    localparam int NREGS = 8;
    localparam int AW    = 3;
    localparam int DW    = 16;

    logic CLK = 1'b0;
    logic reset;
    logic start;
    logic halt_ack;
    logic busy;
    logic done;

    rf_debug_dumper_if #(.AW(AW), .DW(DW)) bus ();

    rf_debug_dumper #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .start    (start),
        .halt_ack (halt_ack),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    // Register file contents and its one-cycle registered A read port
    logic [DW-1:0] regs [NREGS];
    always @(posedge CLK) bus.rf_dataA <= regs[bus.rf_regA];

    int            n_tests = 0;
    int            n_fail  = 0;
    int            exp_q[$];
    int            done_cnt = 0;
    int            done_base;
    int            rdy_mode = 0;
    int            stall_cnt = 0;
    bit            halt_rand = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_idx;
    logic [DW-1:0] prev_data;
    int            cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: wait past the edge, observe on the falling edge, drive next inputs
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        if (reset) begin
            prev_stall = 1'b0;
            stall_cnt  = 0;
            bus.dbg_ready = 1'b1;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.dbg_valid}, 32'd1);
                check("hold_idx",   {29'd0, bus.dbg_idx},   {29'd0, prev_idx});
                check("hold_data",  {16'd0, bus.dbg_data},  {16'd0, prev_data});
            end
            case (rdy_mode)
                0: bus.dbg_ready = 1'b1;
                1: begin
                    if (bus.dbg_valid && stall_cnt < 5) begin
                        bus.dbg_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.dbg_ready = bus.dbg_valid;
                        stall_cnt = 0;
                    end
                end
                default: bus.dbg_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.dbg_valid && bus.dbg_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {29'd0, bus.dbg_idx}, 32'hFFFF_FFFF);
                end else begin
                    check("word_idx",  {29'd0, bus.dbg_idx}, exp_q[0]);
                    check("word_data", {16'd0, bus.dbg_data}, {16'd0, regs[exp_q[0]]});
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = bus.dbg_valid && !bus.dbg_ready;
            prev_idx   = bus.dbg_idx;
            prev_data  = bus.dbg_data;
            if (done) done_cnt++;
            if (halt_rand) halt_ack = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic preload(input bit rand_data);
        for (int i = 0; i < NREGS; i++)
            regs[i] = rand_data ? DW'($urandom) : DW'(16'h1000 + i);
    endtask

    task automatic begin_dump();
        exp_q = {};
        for (int i = 0; i < NREGS; i++) exp_q.push_back(i);
        done_base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_dump(input string tag, input int bound);
        int n;
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        tick();
        check({tag, "_left"},    exp_q.size(), 32'd0);
        check({tag, "_ndone"},   done_cnt - done_base, 32'd1);
        check({tag, "_idle"},    {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_word(input int idx, input string tag);
        int n;
        n = 0;
        while (!(bus.dbg_valid && bus.dbg_idx == AW'(idx)) && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_reached"}, {31'd0, bus.dbg_valid}, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        halt_ack = 1'b0;
        bus.dbg_ready = 1'b1;
        preload(0);
        repeat (3) tick();
        check("rst_own",   {31'd0, bus.rf_own},    32'd0);
        check("rst_regA",  {29'd0, bus.rf_regA},   32'd0);
        check("rst_valid", {31'd0, bus.dbg_valid}, 32'd0);
        check("rst_idx",   {29'd0, bus.dbg_idx},   32'd0);
        check("rst_data",  {16'd0, bus.dbg_data},  32'd0);
        check("rst_busy",  {31'd0, busy},          32'd0);
        check("rst_done",  {31'd0, done},          32'd0);
        reset = 1'b0;
        tick();

        // Basic dump with exact latency
        halt_ack = 1'b1;
        rdy_mode = 0;
        begin_dump();
        cyc = 1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check("basic_latency", cyc, 32'd26);
        tick();
        check("basic_left",  exp_q.size(), 32'd0);
        check("basic_ndone", done_cnt - done_base, 32'd1);
        check("basic_idle",  {31'd0, busy}, 32'd0);

        // Backpressure: five stall cycles per word
        preload(1);
        rdy_mode = 1;
        begin_dump();
        end_dump("bp", 400);

        // Halt gating: nothing owned or sent until halt_ack rises
        preload(1);
        rdy_mode = 0;
        halt_ack = 1'b0;
        begin_dump();
        for (int i = 0; i < 10; i++) begin
            check("gate_own",   {31'd0, bus.rf_own},    32'd0);
            check("gate_valid", {31'd0, bus.dbg_valid}, 32'd0);
            check("gate_busy",  {31'd0, busy},          32'd1);
            tick();
        end
        halt_ack = 1'b1;
        end_dump("gate", 200);

        // Halt drop while capturing register 3
        preload(1);
        begin_dump();
        cyc = 0;
        while (!(bus.rf_own && bus.rf_regA == 3'd3) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("hd_addr3", {31'd0, bus.rf_own}, 32'd1);
        tick();
        halt_ack = 1'b0;
        tick();
        check("hd_release", {31'd0, bus.rf_own}, 32'd0);
        check("hd_next3",   exp_q[0], 32'd3);
        repeat (3) tick();
        check("hd_novalid", {31'd0, bus.dbg_valid}, 32'd0);
        halt_ack = 1'b1;
        end_dump("hd", 200);

        // Reset while word 5 is being offered
        preload(1);
        rdy_mode = 1;
        begin_dump();
        wait_word(5, "rst5");
        reset = 1'b1;
        tick();
        check("mrst_own",   {31'd0, bus.rf_own},    32'd0);
        check("mrst_regA",  {29'd0, bus.rf_regA},   32'd0);
        check("mrst_valid", {31'd0, bus.dbg_valid}, 32'd0);
        check("mrst_idx",   {29'd0, bus.dbg_idx},   32'd0);
        check("mrst_data",  {16'd0, bus.dbg_data},  32'd0);
        check("mrst_busy",  {31'd0, busy},          32'd0);
        check("mrst_done",  {31'd0, done},          32'd0);
        reset = 1'b0;
        rdy_mode = 0;
        tick();
        begin_dump();
        end_dump("mrst", 200);

        // start pulsed mid-dump must be ignored
        preload(1);
        begin_dump();
        wait_word(2, "sb2");
        start = 1'b1;
        tick();
        start = 1'b0;
        end_dump("sb", 200);
        repeat (3) tick();
        check("sb_stay_idle", {31'd0, busy}, 32'd0);

        // Randomized backpressure and halt toggling
        for (int r = 0; r < 6; r++) begin
            preload(1);
            rdy_mode  = 2;
            halt_rand = 1;
            begin_dump();
            end_dump("rnd", 3000);
            halt_rand = 0;
            halt_ack  = 1'b1;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
